// File: rtl/serial_arb_pkg.sv
// Shared types and helpers for the serial transmitter arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_arb_pkg;

    typedef enum logic [1:0] {
        TxReset,
        Idle,
        Send,
        Drain
    } t_arb_state;

    // Widest requester count the one-hot helper supports; callers slice it down.
    localparam int unsigned ONEHOT_W = 32;

    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx, input int unsigned num_req);
        logic [ONEHOT_W-1:0] v;
        v = '0;
        if ((idx < num_req) && (idx < ONEHOT_W)) begin
            v[idx[4:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest requesting index at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to latch the winner.
//   in_req     : request vector
//   in_ptr     : index where the search starts
//   out_winner : chosen index (0 when out_valid is low)
//   out_valid  : at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] in_req,
    input  logic [PTR_W-1:0]   in_ptr,
    output logic [PTR_W-1:0]   out_winner,
    output logic               out_valid
);

    logic [PTR_W-1:0] cand;

    // Walk offsets from the far end down so the smallest offset is assigned last.
    always_comb begin
        out_winner = '0;
        out_valid  = 1'b0;
        cand       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = PTR_W'((int'(in_ptr) + i) % NUM_REQ);
            if (in_req[cand]) begin
                out_winner = cand;
                out_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one serial transmitter between NUM_REQ byte-packet requesters, round-robin, one packet per grant.
// Latency: grant one cycle after Idle sees a request with the transmitter ready; out_ack same cycle as the next-word rising edge.
// Backpressure: requesters hold in_req/in_data until out_ack; the transmitter paces bytes via in_tx_next_word, in_tx_ready gates grant and release.
//   in_clk/in_rst             : clock, async active-low reset
//   in_req/in_data/in_last    : per-requester request, current byte, last-byte flag
//   out_ack/out_grant/out_busy: per-byte acknowledge, one-hot owner, activity flag
//   out_tx_*/in_tx_*          : transmitter reset/enable/data and its next-word/ready handshake
module serial_tx_arbiter
    import serial_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BITS      = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic [NUM_REQ-1:0]            in_req,
    input  logic [NUM_REQ-1:0][BITS-1:0]  in_data,
    input  logic [NUM_REQ-1:0]            in_last,
    output logic [NUM_REQ-1:0]            out_ack,
    output logic [NUM_REQ-1:0]            out_grant,
    output logic                          out_busy,
    output logic                          out_tx_rst,
    output logic                          out_tx_enable,
    output logic [BITS-1:0]               out_tx_data,
    input  logic                          in_tx_next_word,
    input  logic                          in_tx_ready
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    t_arb_state       state_q,   state_d;
    logic [PTR_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [PTR_W-1:0] owner_q,   owner_d;
    logic [CNT_W-1:0] burst_q,   burst_d;
    logic             last_nw_q, last_nw_d;

    logic             next_edge;
    logic [PTR_W-1:0] win_idx;
    logic             win_vld;
    logic [ONEHOT_W-1:0] owner_oh;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .in_req     (in_req),
        .in_ptr     (rr_ptr_q),
        .out_winner (win_idx),
        .out_valid  (win_vld)
    );

    // The transmitter holds next_word as a level; only its rising edge means a byte was taken.
    assign next_edge = in_tx_next_word & ~last_nw_q;
    assign owner_oh  = onehot(32'(owner_q), NUM_REQ);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        burst_d       = burst_q;
        last_nw_d     = in_tx_next_word;
        out_ack       = '0;
        out_grant     = '0;
        out_busy      = 1'b0;
        out_tx_rst    = 1'b0;
        out_tx_enable = 1'b0;
        out_tx_data   = '0;

        case (state_q)
            TxReset: begin
                out_tx_rst = 1'b1;
                state_d    = Idle;
            end
            Idle: begin
                burst_d = '0;
                if (win_vld && in_tx_ready) begin
                    owner_d = win_idx;
                    state_d = Send;
                end
            end
            Send: begin
                out_busy      = 1'b1;
                out_grant     = owner_oh[NUM_REQ-1:0];
                out_tx_enable = 1'b1;
                out_tx_data   = in_data[owner_q];
                // A dropped request aborts the packet; no ack even if an edge lands the same cycle.
                if (!in_req[owner_q]) begin
                    state_d = Drain;
                end else if (next_edge) begin
                    out_ack = owner_oh[NUM_REQ-1:0];
                    burst_d = burst_q + CNT_W'(1);
                    if (in_last[owner_q] || (burst_q + CNT_W'(1) == CNT_W'(MAX_BURST))) begin
                        state_d = Drain;
                    end
                end
            end
            Drain: begin
                out_busy  = 1'b1;
                out_grant = owner_oh[NUM_REQ-1:0];
                if (in_tx_ready) begin
                    rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                    state_d  = Idle;
                end
            end
            default: begin
                state_d = TxReset;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q   <= TxReset;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            burst_q   <= '0;
            last_nw_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            last_nw_q <= last_nw_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter; the bench plays the transmitter's next-word/ready handshake.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_tx_arbiter;

    logic             in_clk;
    logic             in_rst;
    logic [3:0]       in_req;
    logic [3:0][7:0]  in_data;
    logic [3:0]       in_last;
    logic [3:0]       out_ack;
    logic [3:0]       out_grant;
    logic             out_busy;
    logic             out_tx_rst;
    logic             out_tx_enable;
    logic [7:0]       out_tx_data;
    logic             in_tx_next_word;
    logic             in_tx_ready;

    int total = 0;
    int bad   = 0;

    serial_tx_arbiter #(
        .NUM_REQ   (4),
        .BITS      (8),
        .MAX_BURST (2)
    ) dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_req          (in_req),
        .in_data         (in_data),
        .in_last         (in_last),
        .out_ack         (out_ack),
        .out_grant       (out_grant),
        .out_busy        (out_busy),
        .out_tx_rst      (out_tx_rst),
        .out_tx_enable   (out_tx_enable),
        .out_tx_data     (out_tx_data),
        .in_tx_next_word (in_tx_next_word),
        .in_tx_ready     (in_tx_ready)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge in_clk);
        #1;
    endtask

    // Check the owner is presenting the expected byte, then take it: one ack on the
    // rising edge, none while next_word stays high, then a gap cycle to rearm the edge.
    task automatic tx_consume(input int o, input logic [7:0] d);
        logic [3:0] e;
        e = 4'b0001 << o;
        #1;
        chk("send_grant", 32'(out_grant), 32'(e));
        chk("send_data", 32'(out_tx_data), 32'(d));
        chk("send_en", 32'(out_tx_enable), 32'd1);
        in_tx_next_word = 1'b1;
        in_tx_ready     = 1'b0;
        #1;
        chk("ack_edge", 32'(out_ack), 32'(e));
        cyc();
        chk("ack_level", 32'(out_ack), 32'd0);
        in_tx_next_word = 1'b0;
        cyc();
    endtask

    task automatic chk_drain(input int o);
        logic [3:0] e;
        e = 4'b0001 << o;
        #1;
        chk("drain_grant", 32'(out_grant), 32'(e));
        chk("drain_en", 32'(out_tx_enable), 32'd0);
        chk("drain_data", 32'(out_tx_data), 32'd0);
        chk("drain_busy", 32'(out_busy), 32'd1);
    endtask

    task automatic release_to_idle();
        in_tx_ready = 1'b1;
        cyc();
        chk("idle_grant", 32'(out_grant), 32'd0);
        chk("idle_busy", 32'(out_busy), 32'd0);
    endtask

    initial begin
        in_rst          = 1'b0;
        in_req          = '0;
        in_data         = '0;
        in_last         = '0;
        in_tx_next_word = 1'b0;
        in_tx_ready     = 1'b0;

        // Reset state
        #2;
        chk("rst_txrst", 32'(out_tx_rst), 32'd1);
        chk("rst_grant", 32'(out_grant), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_en", 32'(out_tx_enable), 32'd0);
        chk("rst_data", 32'(out_tx_data), 32'd0);
        chk("rst_ack", 32'(out_ack), 32'd0);
        cyc();
        cyc();
        in_rst = 1'b1;
        #1;
        chk("txrst_state", 32'(out_tx_rst), 32'd1);
        cyc();
        chk("txrst_one_cycle", 32'(out_tx_rst), 32'd0);
        chk("idle_busy0", 32'(out_busy), 32'd0);

        // 1: single two-byte packet from requester 0
        in_req[0]   = 1'b1;
        in_data[0]  = 8'h10;
        in_tx_ready = 1'b1;
        cyc();
        tx_consume(0, 8'h10);
        in_data[0] = 8'h01;
        in_last[0] = 1'b1;
        tx_consume(0, 8'h01);
        in_req[0]  = 1'b0;
        in_last[0] = 1'b0;
        chk_drain(0);
        cyc();
        chk("drain_wait_ready", 32'(out_grant), 32'd1);
        release_to_idle();

        // 2: requesters 0 and 1 both pending at reset release
        in_rst     = 1'b0;
        in_req     = 4'b0011;
        in_data[0] = 8'h11;
        in_data[1] = 8'hff;
        in_last    = 4'b0011;
        #1;
        chk("rst2_txrst", 32'(out_tx_rst), 32'd1);
        cyc();
        in_rst = 1'b1;
        cyc();
        chk("rst2_idle_busy", 32'(out_busy), 32'd0);
        cyc();
        tx_consume(0, 8'h11);
        in_req[0] = 1'b0;
        chk_drain(0);
        release_to_idle();
        cyc();
        tx_consume(1, 8'hff);
        in_req[1] = 1'b0;
        chk_drain(1);
        release_to_idle();

        // 3: all four request one-byte packets; pointer starts at 2 and wraps
        in_req  = 4'b1111;
        in_last = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i] = 8'h30 + 8'(i);
        for (int k = 0; k < 4; k++) begin
            cyc();
            tx_consume((2 + k) % 4, 8'h30 + 8'((2 + k) % 4));
            chk_drain((2 + k) % 4);
            release_to_idle();
        end
        in_req  = '0;
        in_last = '0;

        // 4: burst limit 2; requester 2 has five bytes, requester 3 one
        in_req     = 4'b1100;
        in_data[2] = 8'h01;
        in_data[3] = 8'h3c;
        in_last[3] = 1'b1;
        cyc();
        tx_consume(2, 8'h01);
        in_data[2] = 8'h02;
        tx_consume(2, 8'h02);
        in_data[2] = 8'h03;
        chk_drain(2);
        release_to_idle();
        cyc();
        tx_consume(3, 8'h3c);
        in_req[3] = 1'b0;
        chk_drain(3);
        release_to_idle();
        cyc();
        tx_consume(2, 8'h03);
        in_data[2] = 8'h04;
        tx_consume(2, 8'h04);
        in_data[2] = 8'h05;
        in_last[2] = 1'b1;
        chk_drain(2);
        release_to_idle();
        cyc();
        tx_consume(2, 8'h05);
        in_req  = '0;
        in_last = '0;
        chk_drain(2);
        release_to_idle();

        // 5: requester 1 aborts after the first byte of three
        in_req[1]  = 1'b1;
        in_data[1] = 8'ha1;
        cyc();
        tx_consume(1, 8'ha1);
        in_req[1]       = 1'b0;
        in_data[1]      = 8'ha2;
        in_tx_next_word = 1'b1;
        #1;
        chk("abort_no_ack", 32'(out_ack), 32'd0);
        cyc();
        chk("abort_drain_grant", 32'(out_grant), 32'd2);
        chk("abort_drain_en", 32'(out_tx_enable), 32'd0);
        chk("abort_drain_ack", 32'(out_ack), 32'd0);
        in_tx_next_word = 1'b0;
        cyc();
        chk("abort_wait_busy", 32'(out_busy), 32'd1);
        release_to_idle();

        // 6: async reset in the middle of Send, then a clean packet
        in_req[0]  = 1'b1;
        in_data[0] = 8'h77;
        in_last[0] = 1'b1;
        cyc();
        chk("pre_rst_grant", 32'(out_grant), 32'd1);
        #2;
        in_rst          = 1'b0;
        in_tx_next_word = 1'b1;
        #1;
        chk("arst_txrst", 32'(out_tx_rst), 32'd1);
        chk("arst_grant", 32'(out_grant), 32'd0);
        chk("arst_en", 32'(out_tx_enable), 32'd0);
        chk("arst_data", 32'(out_tx_data), 32'd0);
        chk("arst_busy", 32'(out_busy), 32'd0);
        chk("arst_ack", 32'(out_ack), 32'd0);
        in_tx_next_word = 1'b0;
        cyc();
        in_rst = 1'b1;
        cyc();
        chk("arst_release_txrst", 32'(out_tx_rst), 32'd0);
        cyc();
        tx_consume(0, 8'h77);
        in_req[0] = 1'b0;
        chk_drain(0);
        release_to_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
